// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone pipelined RAM slave with address decode, byte lanes and wait states
module wb_ram_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hb0000000,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_wb_stall
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam int         DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  hit_q, hit_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           data_q, data_d;

    logic                  accept;
    logic                  addr_hit;
    logic                  resp_live;
    logic [ADDR_WIDTH-1:0] addr_idx;
    logic                  unused_addr_lsb;

    assign o_wb_stall      = (state_q == ST_WAIT);
    assign accept          = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign addr_hit        = (i_wb_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign addr_idx        = i_wb_addr[ADDR_WIDTH+1:2];
    assign unused_addr_lsb = ^i_wb_addr[1:0];

    // Dropping cyc during the response cycle aborts it, so the pulse is gated live.
    assign resp_live = (state_q == ST_RESP) & i_wb_cyc;
    assign o_wb_ack  = resp_live & hit_q;
    assign o_wb_err  = resp_live & ~hit_q;
    assign o_wb_data = o_wb_ack ? data_q : 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        we_d    = we_q;
        idx_d   = idx_q;
        data_d  = data_q;

        case (state_q)
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    data_d  = (hit_q && !we_q) ? mem[idx_q] : 32'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept overrides the RESP->IDLE default so responses can overlap new requests.
        if (accept) begin
            hit_d = addr_hit;
            we_d  = i_wb_we;
            idx_d = addr_idx;
            if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_INIT;
            end else begin
                state_d = ST_RESP;
                data_d  = (addr_hit && !i_wb_we) ? mem[addr_idx] : 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hit_q   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Memory has no reset; writes commit on the accept edge.
    always_ff @(posedge clk) begin
        if (accept && addr_hit && i_wb_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wb_sel[i]) mem[addr_idx][8*i +: 8] <= i_wb_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - scoreboard bench for wb_ram_slave at 0, 3 and 5 wait states
`timescale 1ns/1ps
module tb_wb_ram_slave;
    localparam int          NI   = 3;
    localparam logic [31:0] BASE = 32'hb0000000;

    typedef struct {
        int          k;
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cyc   [NI];
    logic        stb   [NI];
    logic        we    [NI];
    logic [31:0] adr   [NI];
    logic [31:0] wdat  [NI];
    logic [3:0]  sel   [NI];
    logic [31:0] rdat  [NI];
    logic        ack   [NI];
    logic        err   [NI];
    logic        stall [NI];

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model [NI][1024];
    int          n_vec = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    int          w_cnt;

    wb_ram_slave #(.WAIT_STATES(0)) u_w0 (
        .clk(clk), .reset(reset), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
        .i_wb_addr(adr[0]), .i_wb_data(wdat[0]), .i_wb_sel(sel[0]), .o_wb_data(rdat[0]),
        .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_stall(stall[0]));
    wb_ram_slave #(.WAIT_STATES(3)) u_w3 (
        .clk(clk), .reset(reset), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
        .i_wb_addr(adr[1]), .i_wb_data(wdat[1]), .i_wb_sel(sel[1]), .o_wb_data(rdat[1]),
        .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_stall(stall[1]));
    wb_ram_slave #(.WAIT_STATES(5)) u_w5 (
        .clk(clk), .reset(reset), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we[2]),
        .i_wb_addr(adr[2]), .i_wb_data(wdat[2]), .i_wb_sel(sel[2]), .o_wb_data(rdat[2]),
        .o_wb_ack(ack[2]), .o_wb_err(err[2]), .o_wb_stall(stall[2]));

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int ws(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic logic is_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd4096);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drive a request and hold it until the slave takes it; expectation is queued at accept.
    task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int waits);
        exp_t e;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = s;
        waits = 0;
        while (stall[k] && waits < 64) begin
            step();
            waits++;
        end
        if (stall[k]) check("stall_timeout", 32'(stall[k]), 32'd0);
        if (ws(k) == 0) check("w0_no_stall", 32'(waits), 32'd0);
        e.k   = k;
        e.due = edge_cnt + 1 + ws(k);
        e.err = !is_hit(a);
        e.chk = 1'b1;
        e.data = 32'd0;
        if (is_hit(a)) begin
            if (w) begin
                model[k][word_of(a)] = merge(model[k][word_of(a)], d, s);
                e.chk = 1'b0;
            end else begin
                e.data = model[k][word_of(a)];
            end
        end
        sb.push_back(e);
        step();
    endtask

    task automatic finish_txn(input int k);
        int guard;
        stb[k] = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 64) begin
            step();
            guard++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        cyc[k] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < NI; k++) begin
                if (ack[k] || err[k]) begin
                    check("ack_err_exclusive", 32'(ack[k] & err[k]), 32'd0);
                    if (sb.size() == 0 || sb[0].k != k) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_resp: inst %0d ack=%b err=%b while none expected",
                                 k, ack[k], err[k]);
                    end else begin
                        mon_e = sb.pop_front();
                        check("resp_err", 32'(err[k]), 32'(mon_e.err));
                        check("resp_ack", 32'(ack[k]), 32'(!mon_e.err));
                        if (mon_e.chk) check("resp_data", rdat[k], mon_e.data);
                        check("resp_latency", 32'(edge_cnt), 32'(mon_e.due));
                    end
                end else begin
                    check("data_zero_no_ack", rdat[k], 32'd0);
                end
            end
            if (sb.size() != 0 && edge_cnt > sb[0].due) begin
                mon_e = sb.pop_front();
                check("missing_resp", 32'(edge_cnt), 32'(mon_e.due));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = 32'd0; wdat[k] = 32'd0; sel[k] = 4'd0;
        end
        repeat (3) step();
        for (int k = 0; k < NI; k++) begin
            check("rst_ack", 32'(ack[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
            check("rst_stall", 32'(stall[k]), 32'd0);
            check("rst_data", rdat[k], 32'd0);
        end
        reset = 1'b1;
        step();

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 16; i++) issue(k, 1'b1, BASE + 32'(4*i), $urandom, 4'hf, w_cnt);
            finish_txn(k);
            step();
        end

        issue(0, 1'b1, 32'hb0000010, 32'hdeadbeef, 4'hf, w_cnt);
        finish_txn(0);
        issue(0, 1'b0, 32'hb0000010, 32'd0, 4'hf, w_cnt);
        finish_txn(0);
        for (int i = 0; i < 4; i++) issue(0, 1'b0, BASE + 32'(4*i), 32'd0, 4'hf, w_cnt);
        finish_txn(0);
        issue(0, 1'b1, 32'hb0000020, 32'h11223344, 4'hf, w_cnt);
        issue(0, 1'b1, 32'hb0000020, 32'haabbccdd, 4'b0101, w_cnt);
        issue(0, 1'b0, 32'hb0000020, 32'd0, 4'hf, w_cnt);
        issue(0, 1'b0, 32'ha0000000, 32'd0, 4'hf, w_cnt);
        issue(0, 1'b1, 32'hb0001020, 32'h55555555, 4'hf, w_cnt);
        issue(0, 1'b1, 32'hb0000020, 32'h99999999, 4'h0, w_cnt);
        issue(0, 1'b0, 32'hb0000023, 32'd0, 4'hf, w_cnt);
        finish_txn(0);
        step();

        issue(1, 1'b0, 32'hb0000010, 32'd0, 4'hf, w_cnt);
        issue(1, 1'b0, 32'hb0000020, 32'd0, 4'hf, w_cnt);
        check("w3_stall_cycles", 32'(w_cnt), 32'd3);
        finish_txn(1);
        step();

        issue(2, 1'b1, 32'hb0000030, 32'hcafef00d, 4'hf, w_cnt);
        step();
        cyc[2] = 1'b0; stb[2] = 1'b0;
        void'(sb.pop_back());
        step();
        check("abort_idle_stall", 32'(stall[2]), 32'd0);
        issue(2, 1'b0, 32'hb0000010, 32'd0, 4'hf, w_cnt);
        step();
        cyc[2] = 1'b0; stb[2] = 1'b0;
        void'(sb.pop_back());
        step();
        check("abort_idle_stall", 32'(stall[2]), 32'd0);
        repeat (7) step();
        issue(2, 1'b0, 32'hb0000030, 32'd0, 4'hf, w_cnt);
        finish_txn(2);

        issue(2, 1'b0, 32'hb0000020, 32'd0, 4'hf, w_cnt);
        step();
        reset = 1'b0;
        #1;
        check("midrst_ack", 32'(ack[2]), 32'd0);
        check("midrst_err", 32'(err[2]), 32'd0);
        check("midrst_stall", 32'(stall[2]), 32'd0);
        check("midrst_data", rdat[2], 32'd0);
        sb.delete();
        cyc[2] = 1'b0; stb[2] = 1'b0;
        step();
        reset = 1'b1;
        issue(2, 1'b0, 32'hb0000020, 32'd0, 4'hf, w_cnt);
        finish_txn(2);
        step();

        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 60; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = 32'ha0000000 | ($urandom & 32'h0fffffff);
                else if (r == 1) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
                else if (r == 2) a = BASE - 32'd4;
                else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                issue(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), w_cnt);
                if ($urandom_range(0, 3) == 0) begin
                    finish_txn(k);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
            finish_txn(k);
            step();
        end

        repeat (4) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
